// File: rtl/spi_master_if.sv
// Byte-level handshake plus SPI pins between the SPI master and its user.
// The master modport is the spi_master's view; the slave modport is the user's view.
interface spi_master_if;
   logic       start;
   logic [7:0] tx_data;
   logic       miso;
   logic       sclk;
   logic       mosi;
   logic       ss_n;
   logic [7:0] rx_data;
   logic       busy;
   logic       done;

   modport master (
      input  start, tx_data, miso,
      output sclk, mosi, ss_n, rx_data, busy, done
   );

   modport slave (
      output start, tx_data, miso,
      input  sclk, mosi, ss_n, rx_data, busy, done
   );
endinterface

// File: rtl/spi_master.sv
// Mode-0 SPI master: 8-bit MSB-first frames, SCLK divided from clk by 2*HALF_PERIOD.
// All pin and status outputs come straight from registers.
module spi_master #(
   parameter int HALF_PERIOD = 4
) (
   input  logic          clk,
   input  logic          reset,
   spi_master_if.master  bus
);

   localparam logic [7:0] DIV_LAST = 8'(HALF_PERIOD - 1);

   typedef enum logic [1:0] {IDLE, CP0, CP1, STOP} state_t;

   state_t     state_reg;
   logic [7:0] tx_shift_reg;
   logic [7:0] rx_shift_reg;
   logic [7:0] div_cnt_reg;
   logic [2:0] bit_cnt_reg;
   logic       sclk_reg;
   logic       mosi_reg;
   logic       ss_n_reg;
   logic [7:0] rx_data_reg;
   logic       busy_reg;
   logic       done_reg;
   logic       div_last;

   assign div_last = (div_cnt_reg == DIV_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= IDLE;
         tx_shift_reg <= 8'h00;
         rx_shift_reg <= 8'h00;
         div_cnt_reg  <= 8'h00;
         bit_cnt_reg  <= 3'd0;
         sclk_reg     <= 1'b0;
         mosi_reg     <= 1'b0;
         ss_n_reg     <= 1'b1;
         rx_data_reg  <= 8'h00;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  tx_shift_reg <= bus.tx_data;
                  rx_shift_reg <= 8'h00;
                  bit_cnt_reg  <= 3'd0;
                  div_cnt_reg  <= 8'h00;
                  // First data bit must be on the wire for the whole first low phase.
                  mosi_reg     <= bus.tx_data[7];
                  ss_n_reg     <= 1'b0;
                  busy_reg     <= 1'b1;
                  state_reg    <= CP0;
               end
            end
            CP0: begin
               if (div_last) begin
                  div_cnt_reg  <= 8'h00;
                  sclk_reg     <= 1'b1;
                  rx_shift_reg <= {rx_shift_reg[6:0], bus.miso};
                  state_reg    <= CP1;
               end else begin
                  div_cnt_reg <= div_cnt_reg + 8'd1;
               end
            end
            CP1: begin
               if (div_last) begin
                  div_cnt_reg <= 8'h00;
                  sclk_reg    <= 1'b0;
                  if (bit_cnt_reg == 3'd7) begin
                     state_reg <= STOP;
                  end else begin
                     // Next bit goes out on the falling edge, mirroring the shift.
                     tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
                     mosi_reg     <= tx_shift_reg[6];
                     bit_cnt_reg  <= bit_cnt_reg + 3'd1;
                     state_reg    <= CP0;
                  end
               end else begin
                  div_cnt_reg <= div_cnt_reg + 8'd1;
               end
            end
            STOP: begin
               if (div_last) begin
                  div_cnt_reg <= 8'h00;
                  ss_n_reg    <= 1'b1;
                  rx_data_reg <= rx_shift_reg;
                  done_reg    <= 1'b1;
                  busy_reg    <= 1'b0;
                  state_reg   <= IDLE;
               end else begin
                  div_cnt_reg <= div_cnt_reg + 8'd1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.sclk    = sclk_reg;
   assign bus.mosi    = mosi_reg;
   assign bus.ss_n    = ss_n_reg;
   assign bus.rx_data = rx_data_reg;
   assign bus.busy    = busy_reg;
   assign bus.done    = done_reg;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master at HALF_PERIOD=4, with mosi looped back or miso forced,
// plus a small double-synchronised receiver standing in for the on-chip SPI slave.
module tb_spi_master;

   logic clk = 1'b0;
   logic reset;
   logic loop_en;
   logic miso_val;
   int   total = 0;
   int   bad   = 0;

   spi_master_if bus ();

   assign bus.miso = loop_en ? bus.mosi : miso_val;

   spi_master #(.HALF_PERIOD(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Receiver model: synchronise pins, shift on synchronised sclk rise.
   logic [1:0] s_sclk, s_mosi, s_ss;
   logic       s_sclk_prev;
   logic [2:0] slv_cnt;
   logic [7:0] slv_shift, slv_rx;
   logic       slv_done;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         s_sclk <= 2'b00; s_mosi <= 2'b00; s_ss <= 2'b11; s_sclk_prev <= 1'b0;
         slv_cnt <= 3'd0; slv_shift <= 8'h00; slv_rx <= 8'h00; slv_done <= 1'b0;
      end else begin
         s_sclk      <= {s_sclk[0], bus.sclk};
         s_mosi      <= {s_mosi[0], bus.mosi};
         s_ss        <= {s_ss[0], bus.ss_n};
         s_sclk_prev <= s_sclk[1];
         slv_done    <= 1'b0;
         if (s_ss[1]) begin
            slv_cnt <= 3'd0;
         end else if (s_sclk[1] && !s_sclk_prev) begin
            slv_shift <= {slv_shift[6:0], s_mosi[1]};
            slv_cnt   <= slv_cnt + 3'd1;
            if (slv_cnt == 3'd7) begin
               slv_rx   <= {slv_shift[6:0], s_mosi[1]};
               slv_done <= 1'b1;
            end
         end
      end
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   // One frame started from IDLE; observes 90 cycles after acceptance (cycle 0).
   task automatic run_frame(input logic [7:0] tx, input int poke_cyc, input logic [7:0] poke_tx,
                            output int done_cyc, output int n_done, output int n_rise,
                            output logic [7:0] mosi_bits, output int phase_err, output int busy_err,
                            output logic ss_at_done, output logic [7:0] rx_at_done, output int slv_cyc);
      logic prev_sclk;
      int   run;
      done_cyc = -1; n_done = 0; n_rise = 0; mosi_bits = 8'h00; phase_err = 0; busy_err = 0;
      ss_at_done = 1'b0; rx_at_done = 8'h00; slv_cyc = -1;
      prev_sclk = 1'b0; run = 0;
      @(negedge clk);
      bus.start = 1'b1; bus.tx_data = tx;
      @(posedge clk);
      for (int cyc = 1; cyc <= 90; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin bus.start = 1'b0; bus.tx_data = ~tx; end
         if (cyc == poke_cyc) begin bus.start = 1'b1; bus.tx_data = poke_tx; end
         if (cyc == poke_cyc + 1) bus.start = 1'b0;
         if (bus.sclk != prev_sclk) begin
            if (run != 4) phase_err++;
            run = 1;
            if (bus.sclk) begin
               n_rise++;
               mosi_bits = {mosi_bits[6:0], bus.mosi};
            end
         end else if (!bus.ss_n) begin
            run++;
         end
         if (bus.busy !== (cyc <= 68)) busy_err++;
         if (bus.done) begin
            n_done++;
            if (done_cyc < 0) begin
               done_cyc   = cyc;
               ss_at_done = bus.ss_n;
               rx_at_done = bus.rx_data;
               if (run != 4) phase_err++;
            end
         end
         if (slv_done && slv_cyc < 0) slv_cyc = cyc;
         prev_sclk = bus.sclk;
      end
   endtask

   initial begin
      int         dc, nd, nr, pe, be, sc;
      logic [7:0] mb, rx;
      logic       ss;
      int         d1, d2, ndone;
      logic [7:0] rx1, rx2;
      logic       ss69, ss70;

      reset = 1'b0; loop_en = 1'b1; miso_val = 1'b0;
      bus.start = 1'b0; bus.tx_data = 8'h00;
      repeat (3) @(negedge clk);
      check_val("rst_sclk", 32'(bus.sclk), 32'd0);
      check_val("rst_mosi", 32'(bus.mosi), 32'd0);
      check_val("rst_ss_n", 32'(bus.ss_n), 32'd1);
      check_val("rst_rx", 32'(bus.rx_data), 32'h00);
      check_val("rst_busy", 32'(bus.busy), 32'd0);
      check_val("rst_done", 32'(bus.done), 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // Loopback 0xA5
      run_frame(8'hA5, 0, 8'h00, dc, nd, nr, mb, pe, be, ss, rx, sc);
      check_val("a5_done_cyc", 32'(dc), 32'd69);
      check_val("a5_rx", 32'(rx), 32'hA5);
      check_val("a5_ss_at_done", 32'(ss), 32'd1);
      check_val("a5_rises", 32'(nr), 32'd8);
      check_val("a5_mosi_bits", 32'(mb), 32'hA5);
      check_val("a5_phase_err", 32'(pe), 32'd0);
      check_val("a5_busy_err", 32'(be), 32'd0);
      check_val("a5_n_done", 32'(nd), 32'd1);

      // Forced miso levels
      loop_en = 1'b0; miso_val = 1'b0;
      run_frame(8'h00, 0, 8'h00, dc, nd, nr, mb, pe, be, ss, rx, sc);
      check_val("miso0_rx", 32'(rx), 32'h00);
      check_val("miso0_n_done", 32'(nd), 32'd1);
      check_val("miso0_mosi_bits", 32'(mb), 32'h00);
      miso_val = 1'b1;
      run_frame(8'h00, 0, 8'h00, dc, nd, nr, mb, pe, be, ss, rx, sc);
      check_val("miso1_rx", 32'(rx), 32'hFF);
      check_val("miso1_n_done", 32'(nd), 32'd1);

      // start during a frame is ignored; receiver model checks the wire
      loop_en = 1'b1;
      run_frame(8'h3C, 10, 8'h11, dc, nd, nr, mb, pe, be, ss, rx, sc);
      check_val("poke_n_done", 32'(nd), 32'd1);
      check_val("poke_mosi_bits", 32'(mb), 32'h3C);
      check_val("poke_rx", 32'(rx), 32'h3C);
      check_val("poke_done_cyc", 32'(dc), 32'd69);
      check_val("slave_rx", 32'(slv_rx), 32'h3C);
      check_val("slave_before_master", 32'(sc > 0 && sc < dc), 32'd1);

      // Back-to-back frames with start held high
      d1 = -1; d2 = -1; ndone = 0; rx1 = 8'h00; rx2 = 8'h00; ss69 = 1'b0; ss70 = 1'b1;
      @(negedge clk);
      bus.start = 1'b1; bus.tx_data = 8'h81;
      @(posedge clk);
      for (int cyc = 1; cyc <= 150; cyc++) begin
         @(negedge clk);
         if (cyc == 1) bus.tx_data = 8'h7E;
         if (cyc == 70) bus.start = 1'b0;
         if (cyc == 69) ss69 = bus.ss_n;
         if (cyc == 70) ss70 = bus.ss_n;
         if (bus.done) begin
            ndone++;
            if (d1 < 0) begin d1 = cyc; rx1 = bus.rx_data; end
            else if (d2 < 0) begin d2 = cyc; rx2 = bus.rx_data; end
         end
      end
      check_val("b2b_done1_cyc", 32'(d1), 32'd69);
      check_val("b2b_rx1", 32'(rx1), 32'h81);
      check_val("b2b_ss_done_cycle", 32'(ss69), 32'd1);
      check_val("b2b_ss_next_cycle", 32'(ss70), 32'd0);
      check_val("b2b_done2_cyc", 32'(d2), 32'd138);
      check_val("b2b_rx2", 32'(rx2), 32'h7E);
      check_val("b2b_n_done", 32'(ndone), 32'd2);

      // Reset in the middle of a frame (sclk high at cycle 30)
      @(negedge clk);
      bus.start = 1'b1; bus.tx_data = 8'h5A;
      @(posedge clk);
      ndone = 0;
      for (int cyc = 1; cyc <= 30; cyc++) begin
         @(negedge clk);
         if (cyc == 1) bus.start = 1'b0;
         if (bus.done) ndone++;
      end
      check_val("pre_rst_sclk", 32'(bus.sclk), 32'd1);
      reset = 1'b0;
      #1;
      check_val("mid_rst_sclk", 32'(bus.sclk), 32'd0);
      check_val("mid_rst_ss_n", 32'(bus.ss_n), 32'd1);
      check_val("mid_rst_busy", 32'(bus.busy), 32'd0);
      check_val("mid_rst_rx", 32'(bus.rx_data), 32'h00);
      repeat (3) begin
         @(negedge clk);
         if (bus.done) ndone++;
      end
      reset = 1'b1;
      repeat (80) begin
         @(negedge clk);
         if (bus.done) ndone++;
      end
      check_val("mid_rst_no_done", 32'(ndone), 32'd0);
      run_frame(8'hC3, 0, 8'h00, dc, nd, nr, mb, pe, be, ss, rx, sc);
      check_val("post_rst_done_cyc", 32'(dc), 32'd69);
      check_val("post_rst_rx", 32'(rx), 32'hC3);
      check_val("post_rst_n_done", 32'(nd), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI master (initiator) for the SPI subsystem; the counterpart to the on-chip SPI slave receiver.
- Fixed mode 0: CPOL=0, CPHA=0, 8-bit frames, MSB first, single slave select.
- Generates SCLK from the system clock by a programmable divider.
- Drives MOSI and SS_n, captures MISO, and reports each completed byte with a one-cycle done pulse.

Parameters:
HALF_PERIOD, 4, SCLK half-period in clk cycles; legal range 2..255. Values of 4 or more are required when driving the double-synchronised slave.

Ports:
clk      input   1  system clock, all logic on rising edge
reset    input   1  asynchronous, active-low reset (0 = reset asserted)
start    input   1  request a transfer; sampled only in IDLE
tx_data  input   8  byte to send; latched in the cycle start is accepted
miso     input   1  serial data from slave; sampled directly with no synchroniser (slave is synchronous to clk)
sclk     output  1  SPI clock, idle low
mosi     output  1  serial data to slave
ss_n     output  1  slave select, active low
rx_data  output  8  last received byte; holds its value until the next done
busy     output  1  high from the cycle after start acceptance until done
done     output  1  one-cycle pulse when a byte completes

Behaviour:
- Reset (reset=0, asynchronous) values:
  - sclk=0, mosi=0, ss_n=1, rx_data=0x00, busy=0, done=0.
  - State IDLE; shift registers, bit counter and divider counter cleared.
- Reset asserted mid-transfer aborts the frame immediately: ss_n goes high, sclk goes low, and no done is produced.
- All outputs are registered.
- States:
  - IDLE:
    - sclk=0, ss_n=1.
    - If start=1: latch tx_data into tx_shift, clear rx_shift, set bit_cnt=0 and div_cnt=0, then go to CP0.
    - If start=0: stay in IDLE.
  - CP0 (SCLK low phase):
    - ss_n=0, sclk=0, mosi=tx_shift[7].
    - When div_cnt reaches HALF_PERIOD-1: go to CP1, set sclk=1, shift miso into rx_shift LSB ({rx_shift[6:0], miso}), and reset div_cnt.
  - CP1 (SCLK high phase):
    - sclk=1.
    - When div_cnt reaches HALF_PERIOD-1 and bit_cnt=7: go to STOP with sclk=0.
    - When div_cnt reaches HALF_PERIOD-1 and bit_cnt<7: tx_shift <<= 1, bit_cnt+1, go to CP0 with sclk=0.
  - STOP (SS hold):
    - sclk=0, ss_n=0, held for HALF_PERIOD cycles.
    - On exit: ss_n=1, rx_data<=rx_shift, done=1 for exactly one cycle, busy=0, return to IDLE.
- MOSI changes only on SCLK falling edges or at frame start, and is stable for a full SCLK high phase around each rising edge.
- MISO is sampled on the SCLK rising edge (the cycle sclk goes 0 to 1).
- Latency, with start accepted in cycle 0:
  - ss_n falls in cycle 1.
  - First sclk rise in cycle 1+HALF_PERIOD.
  - done in cycle 1+17*HALF_PERIOD (69 for default), with ss_n=1 in that same cycle.
  - Exactly 8 SCLK rising edges per frame; bit_cnt is 3 bits and never wraps within a frame.
- start while busy is ignored; tx_data changes during a frame have no effect.
- start=1 in the done cycle is accepted (the state is IDLE), so the next frame begins back-to-back with ss_n high for one cycle.
- busy=1 in every cycle where the state is not IDLE.

Test Plan:
- Loopback: mosi tied to miso, HALF_PERIOD=4, start with tx_data=0xA5.
  - Required: 8 sclk pulses of 4 high / 4 low cycles.
  - Required: mosi bit sequence 1,0,1,0,0,1,0,1.
  - Required: done in cycle 69, rx_data=0xA5, ss_n high in the same cycle.
- miso held at 0, then at 1, tx_data=0x00 -> rx_data=0x00, then 0xFF; done once per frame.
- start pulsed again in cycle 10 of a frame with tx_data=0x11 while sending 0x3C -> ignored; only one done, mosi still carries 0x3C.
- start held high for two frames (0x81, then 0x7E) -> second ss_n fall one cycle after the first done; both done pulses present; each rx_data matches its loopback byte.
- reset driven low at cycle 30 of a frame -> sclk=0, ss_n=1, busy=0, rx_data=0x00 immediately, no done; a fresh start after release completes normally.
- Paired with the SPI slave receiver, master sends 0x3C -> slave rx_data=0x3C with slave done asserted before master done.
